// File: rtl/reg_writeback_if.sv
// Writeback bus: ALU and LSU result handshakes, register file write port,
// and decode-stage hazard query. The pipeline side uses the master modport,
// the writeback queue uses the slave modport.
interface reg_writeback_if #(
    parameter int XLEN = 32
);
    // ALU result handshake
    logic            i_alu_valid;
    logic            o_alu_ready;
    logic [4:0]      i_alu_rd;
    logic [XLEN-1:0] i_alu_data;

    // Load result handshake
    logic            i_lsu_valid;
    logic            o_lsu_ready;
    logic [4:0]      i_lsu_rd;
    logic [XLEN-1:0] i_lsu_data;
    logic [2:0]      i_lsu_funct3;
    logic [1:0]      i_lsu_addr_lo;

    // Register file write port
    logic            i_wb_hold;
    logic            o_wr;
    logic [4:0]      o_rd;
    logic [XLEN-1:0] o_write_data;

    // Hazard query and status
    logic [4:0]      i_rs1;
    logic [4:0]      i_rs2;
    logic            o_hazard1;
    logic            o_hazard2;
    logic            o_empty;

    modport master (
        output i_alu_valid, i_alu_rd, i_alu_data,
        output i_lsu_valid, i_lsu_rd, i_lsu_data, i_lsu_funct3, i_lsu_addr_lo,
        output i_wb_hold, i_rs1, i_rs2,
        input  o_alu_ready, o_lsu_ready,
        input  o_wr, o_rd, o_write_data,
        input  o_hazard1, o_hazard2, o_empty
    );

    modport slave (
        input  i_alu_valid, i_alu_rd, i_alu_data,
        input  i_lsu_valid, i_lsu_rd, i_lsu_data, i_lsu_funct3, i_lsu_addr_lo,
        input  i_wb_hold, i_rs1, i_rs2,
        output o_alu_ready, o_lsu_ready,
        output o_wr, o_rd, o_write_data,
        output o_hazard1, o_hazard2, o_empty
    );
endinterface

// File: rtl/reg_writeback.sv
// Writeback queue in front of the register file write port.
// Accepts ALU and load results (LSU has priority), formats load data,
// buffers results in order and drains one write per cycle. Reports
// pending-write hazards for the decode stage source registers.
// DEPTH must be a power of two and at least 2; load formatting assumes XLEN = 32.
module reg_writeback #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    reg_writeback_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } entry_t;

    // Extract and extend the addressed byte/half of an aligned memory word.
    // Unlisted funct3 codes behave as LW.
    function automatic logic [XLEN-1:0] format_load(
        input logic [2:0]      funct3,
        input logic [1:0]      addr_lo,
        input logic [XLEN-1:0] raw
    );
        logic [XLEN-1:0] byte_sh;
        logic [XLEN-1:0] half_sh;
        byte_sh = raw >> {addr_lo, 3'b000};
        half_sh = raw >> {addr_lo[1], 4'b0000};
        case (funct3)
            F3_LB:   format_load = {{(XLEN-8){byte_sh[7]}}, byte_sh[7:0]};
            F3_LH:   format_load = {{(XLEN-16){half_sh[15]}}, half_sh[15:0]};
            F3_LBU:  format_load = {{(XLEN-8){1'b0}}, byte_sh[7:0]};
            F3_LHU:  format_load = {{(XLEN-16){1'b0}}, half_sh[15:0]};
            default: format_load = raw;
        endcase
    endfunction

    entry_t            mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic              full;
    logic              lsu_fire;
    logic              alu_fire;
    logic              push;
    logic              pop;
    entry_t            push_entry;
    entry_t            head;

    logic              wr_q;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   data_q;

    logic [DEPTH-1:0]  occupied;
    logic              hazard1;
    logic              hazard2;

    assign full     = (count == CNT_FULL);
    assign lsu_fire = bus.i_lsu_valid && !full;
    assign alu_fire = bus.i_alu_valid && !full && !bus.i_lsu_valid;
    assign pop      = (count != '0) && !bus.i_wb_hold;
    assign head     = mem[rd_ptr];

    // Select the accepted result; rd = 0 completes the handshake but is dropped.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        push_entry = '0;
        push       = 1'b0;
        if (lsu_fire) begin
            push_entry.rd   = bus.i_lsu_rd;
            push_entry.data = format_load(bus.i_lsu_funct3, bus.i_lsu_addr_lo, bus.i_lsu_data);
            push            = (bus.i_lsu_rd != 5'd0);
        end else if (alu_fire) begin
            push_entry.rd   = bus.i_alu_rd;
            push_entry.data = bus.i_alu_data;
            push            = (bus.i_alu_rd != 5'd0);
        end
    end

    // Queue pointers and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of block order.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; count decides which slots are live, so stale contents are never observed.
        if (push) mem[wr_ptr] <= push_entry;
    end

    // Register file write port: one pop per cycle into the output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q   <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
        end else begin
            wr_q <= pop;
            if (pop) begin
                rd_q   <= head.rd;
                data_q <= head.data;
            end
        end
    end

    // A slot is live when its distance from the read pointer is below count.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_occ
        logic [PTR_W-1:0] slot_off;
        assign slot_off     = PTR_W'(gi) - rd_ptr;
        assign occupied[gi] = ({1'b0, slot_off} < count);
    end

    // Pending-write hazard: any live entry or the write in flight targets rs.
    always_comb begin
        hazard1 = 1'b0;
        hazard2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (occupied[i] && (mem[i].rd == bus.i_rs1)) hazard1 = 1'b1;
            if (occupied[i] && (mem[i].rd == bus.i_rs2)) hazard2 = 1'b1;
        end
        if (wr_q && (rd_q == bus.i_rs1)) hazard1 = 1'b1;
        if (wr_q && (rd_q == bus.i_rs2)) hazard2 = 1'b1;
    end

    assign bus.o_lsu_ready  = !full;
    assign bus.o_alu_ready  = !full && !bus.i_lsu_valid;
    assign bus.o_wr         = wr_q;
    assign bus.o_rd         = rd_q;
    assign bus.o_write_data = data_q;
    assign bus.o_hazard1    = hazard1 && (bus.i_rs1 != 5'd0);
    assign bus.o_hazard2    = hazard2 && (bus.i_rs2 != 5'd0);
    assign bus.o_empty      = (count == '0) && !wr_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: reset, single write latency,
// load formatting vectors, arbitration, full/wrap, rd = 0 and reset flush.
module tb_reg_writeback;
    logic clk;
    logic rst;

    reg_writeback_if #(.XLEN(32)) bus ();

    reg_writeback #(.DEPTH(4), .XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0]  funct3;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [4:0]  rd;
        logic [31:0] exp;
    } load_vec_t;

    load_vec_t vecs [11];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_alu_valid   = 1'b0;
        bus.i_alu_rd      = '0;
        bus.i_alu_data    = '0;
        bus.i_lsu_valid   = 1'b0;
        bus.i_lsu_rd      = '0;
        bus.i_lsu_data    = '0;
        bus.i_lsu_funct3  = '0;
        bus.i_lsu_addr_lo = '0;
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [31:0] data);
        bus.i_alu_valid = 1'b1;
        bus.i_alu_rd    = rd;
        bus.i_alu_data  = data;
    endtask

    task automatic check_write(input string name, input logic [4:0] rd, input logic [31:0] data);
        check({name, " o_wr"}, 32'(bus.o_wr), 32'd1);
        check({name, " o_rd"}, 32'(bus.o_rd), 32'(rd));
        check({name, " data"}, bus.o_write_data, data);
    endtask

    initial begin
        vecs[0]  = '{3'b000, 2'd1, 32'h123480FF, 5'd1,  32'hFFFFFF80};
        vecs[1]  = '{3'b100, 2'd1, 32'h123480FF, 5'd2,  32'h00000080};
        vecs[2]  = '{3'b001, 2'd0, 32'h123480FF, 5'd3,  32'hFFFF80FF};
        vecs[3]  = '{3'b101, 2'd2, 32'h123480FF, 5'd4,  32'h00001234};
        vecs[4]  = '{3'b010, 2'd3, 32'h123480FF, 5'd5,  32'h123480FF};
        vecs[5]  = '{3'b000, 2'd0, 32'h123480FF, 5'd6,  32'hFFFFFFFF};
        vecs[6]  = '{3'b100, 2'd3, 32'h123480FF, 5'd7,  32'h00000012};
        vecs[7]  = '{3'b001, 2'd2, 32'h123480FF, 5'd8,  32'h00001234};
        vecs[8]  = '{3'b101, 2'd1, 32'h123480FF, 5'd9,  32'h000080FF};
        vecs[9]  = '{3'b011, 2'd1, 32'hCAFEF00D, 5'd10, 32'hCAFEF00D};
        vecs[10] = '{3'b110, 2'd2, 32'h8000_0001, 5'd31, 32'h80000001};

        // ---------------- Reset values ----------------
        rst = 1'b1;
        idle_inputs();
        bus.i_wb_hold = 1'b0;
        bus.i_rs1     = 5'd5;
        bus.i_rs2     = 5'd0;
        #1;
        check("reset o_wr",      32'(bus.o_wr), 32'd0);
        check("reset o_rd",      32'(bus.o_rd), 32'd0);
        check("reset data",      bus.o_write_data, 32'd0);
        check("reset o_empty",   32'(bus.o_empty), 32'd1);
        check("reset lsu_ready", 32'(bus.o_lsu_ready), 32'd1);
        check("reset alu_ready", 32'(bus.o_alu_ready), 32'd1);
        check("reset hazard1",   32'(bus.o_hazard1), 32'd0);
        #11 rst = 1'b0;
        tick();

        // ---------------- Single ALU write ----------------
        drive_alu(5'd5, 32'hABCDEFFF);
        #1;
        check("alu ready",           32'(bus.o_alu_ready), 32'd1);
        check("alu hazard before k", 32'(bus.o_hazard1), 32'd0);
        tick();                               // edge k: accepted
        idle_inputs();
        #1;
        check("alu k o_wr",      32'(bus.o_wr), 32'd0);
        check("alu k hazard1",   32'(bus.o_hazard1), 32'd1);
        check("alu k o_empty",   32'(bus.o_empty), 32'd0);
        tick();                               // edge k+1: pop
        check_write("alu k+1", 5'd5, 32'hABCDEFFF);
        check("alu k+1 hazard1", 32'(bus.o_hazard1), 32'd1);
        tick();                               // edge k+2: committed
        check("alu k+2 o_wr",    32'(bus.o_wr), 32'd0);
        check("alu k+2 hazard1", 32'(bus.o_hazard1), 32'd0);
        check("alu k+2 o_empty", 32'(bus.o_empty), 32'd1);
        check("alu k+2 data held", bus.o_write_data, 32'hABCDEFFF);

        // ---------------- Load formatting vectors ----------------
        bus.i_rs1 = 5'd0;
        for (int i = 0; i < 11; i++) begin
            bus.i_lsu_valid   = 1'b1;
            bus.i_lsu_rd      = vecs[i].rd;
            bus.i_lsu_data    = vecs[i].data;
            bus.i_lsu_funct3  = vecs[i].funct3;
            bus.i_lsu_addr_lo = vecs[i].addr;
            #1;
            check($sformatf("load[%0d] lsu_ready", i), 32'(bus.o_lsu_ready), 32'd1);
            tick();
            idle_inputs();
            #1;
            check($sformatf("load[%0d] no bypass", i), 32'(bus.o_wr), 32'd0);
            tick();
            check_write($sformatf("load[%0d]", i), vecs[i].rd, vecs[i].exp);
            tick();
            check($sformatf("load[%0d] o_wr drop", i), 32'(bus.o_wr), 32'd0);
        end

        // ---------------- Same-cycle contention ----------------
        bus.i_rs1 = 5'd9;
        bus.i_rs2 = 5'd7;
        drive_alu(5'd7, 32'h11);
        bus.i_lsu_valid   = 1'b1;
        bus.i_lsu_rd      = 5'd9;
        bus.i_lsu_data    = 32'h22;
        bus.i_lsu_funct3  = 3'b010;
        bus.i_lsu_addr_lo = 2'd0;
        #1;
        check("cont alu_ready low",  32'(bus.o_alu_ready), 32'd0);
        check("cont lsu_ready high", 32'(bus.o_lsu_ready), 32'd1);
        tick();                               // LSU accepted
        bus.i_lsu_valid = 1'b0;
        #1;
        check("cont alu_ready next", 32'(bus.o_alu_ready), 32'd1);
        check("cont hazard1 queued", 32'(bus.o_hazard1), 32'd1);
        check("cont hazard2 before", 32'(bus.o_hazard2), 32'd0);
        tick();                               // ALU accepted, rd 9 popped
        idle_inputs();
        #1;
        check_write("cont first", 5'd9, 32'h22);
        check("cont hazard1 in flight", 32'(bus.o_hazard1), 32'd1);
        check("cont hazard2 queued",    32'(bus.o_hazard2), 32'd1);
        tick();
        check_write("cont second", 5'd7, 32'h11);
        check("cont hazard1 clear", 32'(bus.o_hazard1), 32'd0);
        check("cont hazard2 write", 32'(bus.o_hazard2), 32'd1);
        tick();
        check("cont done o_wr",    32'(bus.o_wr), 32'd0);
        check("cont done hazard2", 32'(bus.o_hazard2), 32'd0);

        // ---------------- Full and wrap ----------------
        bus.i_rs1 = 5'd0;
        bus.i_rs2 = 5'd3;
        bus.i_wb_hold = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive_alu(5'(i), 32'h100 * i);
            #1;
            check($sformatf("fill %0d alu_ready", i), 32'(bus.o_alu_ready), 32'd1);
            tick();
            check($sformatf("fill %0d held o_wr", i), 32'(bus.o_wr), 32'd0);
        end
        drive_alu(5'd20, 32'hDEAD);
        #1;
        check("full alu_ready", 32'(bus.o_alu_ready), 32'd0);
        check("full lsu_ready", 32'(bus.o_lsu_ready), 32'd0);
        check("full hazard2",   32'(bus.o_hazard2), 32'd1);
        check("full rs0 hazard1", 32'(bus.o_hazard1), 32'd0);
        idle_inputs();
        bus.i_wb_hold = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_write($sformatf("drain %0d", i), 5'(i), 32'h100 * i);
            if (i == 1)
                check("drain slot freed", 32'(bus.o_lsu_ready), 32'd1);
        end
        tick();
        check("drain done o_wr",    32'(bus.o_wr), 32'd0);
        check("drain done o_empty", 32'(bus.o_empty), 32'd1);

        for (int i = 0; i < 4; i++) begin
            drive_alu(5'(5 + i), 32'h5000 + 32'(i));
            tick();
            if (i == 0)
                check("wrap first no bypass", 32'(bus.o_wr), 32'd0);
            else
                check_write($sformatf("wrap %0d", 4 + i), 5'(4 + i), 32'h5000 + 32'(i - 1));
        end
        idle_inputs();
        tick();
        check_write("wrap 8", 5'd8, 32'h5003);
        tick();
        check("wrap done o_wr", 32'(bus.o_wr), 32'd0);

        // ---------------- rd = 0 ----------------
        drive_alu(5'd0, 32'hFFFF_0000);
        #1;
        check("rd0 alu_ready", 32'(bus.o_alu_ready), 32'd1);
        tick();
        idle_inputs();
        #1;
        check("rd0 o_empty", 32'(bus.o_empty), 32'd1);
        tick();
        check("rd0 no o_wr",   32'(bus.o_wr), 32'd0);
        check("rd0 o_empty 2", 32'(bus.o_empty), 32'd1);

        // ---------------- Reset flush mid-operation ----------------
        bus.i_wb_hold = 1'b1;
        bus.i_rs1 = 5'd11;
        drive_alu(5'd10, 32'hA0A0);
        tick();
        drive_alu(5'd11, 32'hB1B1);
        tick();
        idle_inputs();
        #1;
        check("flush queued o_empty", 32'(bus.o_empty), 32'd0);
        check("flush queued hazard1", 32'(bus.o_hazard1), 32'd1);
        bus.i_wb_hold = 1'b0;
        tick();
        check_write("flush first", 5'd10, 32'hA0A0);
        #2 rst = 1'b1;                        // asynchronous, between edges
        #1;
        check("flush rst o_wr",      32'(bus.o_wr), 32'd0);
        check("flush rst o_empty",   32'(bus.o_empty), 32'd1);
        check("flush rst lsu_ready", 32'(bus.o_lsu_ready), 32'd1);
        check("flush rst alu_ready", 32'(bus.o_alu_ready), 32'd1);
        check("flush rst hazard1",   32'(bus.o_hazard1), 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("flush after %0d o_wr", i), 32'(bus.o_wr), 32'd0);
            check($sformatf("flush after %0d o_empty", i), 32'(bus.o_empty), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_writeback.md
# reg_writeback

Writeback queue in front of the register file write port. It accepts completed results from the ALU and the load/store unit over valid/ready handshakes, formats load data (byte/half select, sign/zero extension), and buffers the results in order. It then drives the register file's single write port (`i_wr`, `i_rd`, `i_write_data`) with one write per cycle. It also reports pending-write hazards for the decode stage's `rs1`/`rs2`.

## Interface
- `DEPTH`, 4: queue entries; power of two, at least 2.
- `XLEN`, 32: data width; load formatting assumes 32.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `i_alu_valid`  in  1  ALU result valid.
- `o_alu_ready`  out  1  ALU result accepted this cycle when high together with `i_alu_valid`.
- `i_alu_rd`  in  5  ALU destination register.
- `i_alu_data`  in  XLEN  ALU result.
- `i_lsu_valid`  in  1  load result valid.
- `o_lsu_ready`  out  1  load result accepted this cycle when high together with `i_lsu_valid`.
- `i_lsu_rd`  in  5  load destination register.
- `i_lsu_data`  in  XLEN  raw aligned memory word.
- `i_lsu_funct3`  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- `i_lsu_addr_lo`  in  2  byte offset of the load address.
- `i_wb_hold`  in  1  write port unavailable; the queue must not drain.
- `o_wr`  out  1  connects to register file `i_wr`.
- `o_rd`  out  5  connects to register file `i_rd`.
- `o_write_data`  out  XLEN  connects to register file `i_write_data`.
- `i_rs1`, `i_rs2`  in  5 each  decode-stage source registers.
- `o_hazard1`, `o_hazard2`  out  1 each  write to `i_rs1` / `i_rs2` still pending.
- `o_empty`  out  1  queue empty and no write in flight.

## Operation
- **Arbitration:** at most one enqueue per cycle, and LSU has priority.
  - `o_lsu_ready = !full`.
  - `o_alu_ready = !full && !i_lsu_valid`.
- **rd = 0 results:** handshake completes with ready high, but nothing is enqueued and nothing is written.
- **Load formatting at enqueue:**
  - Shift `i_lsu_data` right by 8×`i_lsu_addr_lo` for bytes, or by 16×`i_lsu_addr_lo[1]` for halves.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - LW passes data unchanged and ignores `addr_lo`.
  - funct3 011, 110 and 111 are treated as LW.
- **Queue:** circular buffer with read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a count from 0 to DEPTH.
  - `full = (count == DEPTH)`.
  - Entries hold {rd, data}.
- **Drain:** each edge where `count > 0` and `!i_wb_hold`:
  - pop the head into the output register;
  - set `o_wr` = 1 with `o_rd`/`o_write_data` from that entry.
  - Otherwise `o_wr` = 0 on that edge. `o_rd`/`o_write_data` hold their last values.
- **Simultaneous push and pop:** allowed, and count is unchanged. There is no same-cycle bypass of an empty queue.
- **Order:** writes leave in exact acceptance order.
- **Hazard:** combinational; excludes rs = 0.
  - `o_hazard1` is high iff `i_rs1` matches the rd of any occupied entry, or matches `o_rd` while `o_wr` = 1.
  - `o_hazard2` follows the same rule for `i_rs2`.
- **Empty flag:** `o_empty = (count == 0) && !o_wr`.

## Timing
- **Reset values:** count, pointers, `o_wr`, `o_rd` and `o_write_data` are all 0. `o_empty` = 1. Both readies are 1 (given `i_lsu_valid` = 0). Hazards are 0.
- **Reset mid-operation:** all queued entries are dropped, and no `o_wr` pulse appears after `rst` asserts.
- **Latency:** a result accepted at edge k into an empty queue, with hold low, pops at edge k+1.
  - `o_wr` is high from k+1 to k+2.
  - The register file commits at edge k+2.
- **Hold:** `i_wb_hold` sampled high at an edge means no pop. `o_wr` drops after that edge.
- **Full queue:** ready is low for the whole cycle. A pop at that edge frees a slot, visible next cycle.
- **Throughput:** one write per cycle sustained.

## Test plan
- **Reset:** assert `rst` asynchronously between edges → `o_wr` = 0, `o_empty` = 1, `o_lsu_ready` = `o_alu_ready` = 1 immediately.
- **Single ALU write:** ALU rd = 5, data 0xABCDEFFF, accepted at edge k → `o_wr` = 1, `o_rd` = 5, `o_write_data` = 0xABCDEFFF during k+1..k+2. With `i_rs1` = 5, `o_hazard1` is high from k until k+2.
- **Load formatting:** `i_lsu_data` = 0x123480FF.
  - LB, addr 1 → 0xFFFFFF80.
  - LBU, addr 1 → 0x00000080.
  - LH, addr 0 → 0xFFFF80FF.
  - LHU, addr 2 → 0x00001234.
  - LW, addr 3 → 0x123480FF.
- **Same-cycle contention:** ALU (rd 7, 0x11) and LSU (rd 9, LW 0x22) both valid → `o_alu_ready` = 0 and LSU is accepted. ALU is accepted the next cycle. Writes appear as rd 9 then rd 7 on consecutive cycles.
- **Full and wrap:** hold `i_wb_hold` = 1, enqueue rd 1..4 → both readies are 0 after the 4th. Release hold → four consecutive `o_wr` pulses with rd 1,2,3,4. Then enqueue rd 5..8 → pointers wrap and the order is preserved.
- **rd = 0 and reset flush:**
  - ALU rd = 0 with valid → accepted, with no `o_wr` and `o_empty` staying 1.
  - Enqueue two results with hold high, then pulse `rst` → no writes follow and `o_empty` = 1.
